// File: rtl/led_matrix_pkg.sv
// Shared constants for the multiplexed LED matrix scanner.
// Default geometry, timing and the idle pin level.
package led_matrix_pkg;

   localparam int DEF_NUM_COLS     = 4;
   localparam int DEF_NUM_ROWS     = 8;
   localparam int DEF_SCAN_DIV     = 3000;
   localparam int DEF_BLANK_CYCLES = 24;
   localparam int DEF_BRIGHT_BITS  = 3;

   // Pins are active-low, so "all off" is all ones.
   localparam logic OFF = 1'b1;

   function automatic int cbits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/led_slot_timer.sv
// Slot, column and PWM counters for the LED matrix scanner.
// Exports phase and wrap strobes to the top level.
module led_slot_timer
   import led_matrix_pkg::*;
#(
   parameter int NUM_COLS     = DEF_NUM_COLS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int BRIGHT_BITS  = DEF_BRIGHT_BITS
) (
   input  logic                       clk12MHz,
   input  logic                       rst_n,
   output logic                       blank,
   output logic [cbits(NUM_COLS)-1:0] col_idx,
   output logic [BRIGHT_BITS-1:0]     pwm_cnt,
   output logic                       slot_wrap,
   output logic                       frame_wrap
);

   localparam int SW = cbits(SCAN_DIV);
   localparam int CW = cbits(NUM_COLS);

   logic [SW-1:0] slot_cnt;

   assign blank      = slot_cnt < SW'(BLANK_CYCLES);
   assign slot_wrap  = slot_cnt == SW'(SCAN_DIV - 1);
   assign frame_wrap = slot_wrap && (col_idx == CW'(NUM_COLS - 1));

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         col_idx  <= '0;
         pwm_cnt  <= '0;
      end else begin
         slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
         if (slot_wrap)
            col_idx <= frame_wrap ? '0 : col_idx + 1'b1;
         // PWM restarts at 0 on the first active cycle of every slot
         pwm_cnt <= (blank || slot_wrap) ? '0 : pwm_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered, PWM-dimmed scanner for an active-low LED matrix.
// Frames are swapped in only at frame boundaries to avoid tearing.
module led_matrix_scanner
   import led_matrix_pkg::*;
#(
   parameter int NUM_COLS     = DEF_NUM_COLS,
   parameter int NUM_ROWS     = DEF_NUM_ROWS,
   parameter int SCAN_DIV     = DEF_SCAN_DIV,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int BRIGHT_BITS  = DEF_BRIGHT_BITS
) (
   input  logic                         clk12MHz,
   input  logic                         rst_n,
   input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
   input  logic                         frame_valid,
   output logic                         frame_ready,
   input  logic [BRIGHT_BITS-1:0]       brightness,
   output logic [NUM_ROWS-1:0]          led_n,
   output logic [NUM_COLS-1:0]          lcol_n,
   output logic                         frame_start
);

   localparam int CW = cbits(NUM_COLS);
   localparam int FW = NUM_COLS * NUM_ROWS;

   logic                   blank;
   logic [CW-1:0]          col_idx;
   logic [BRIGHT_BITS-1:0] pwm_cnt;
   logic                   slot_wrap;
   logic                   frame_wrap;

   logic [FW-1:0]       pend_buf;
   logic [FW-1:0]       active;
   logic                pending;
   logic                first_q;
   logic                lit;
   logic                accept;
   logic [NUM_ROWS-1:0] col_bits;
   logic [NUM_COLS-1:0] col_oh;

   led_slot_timer #(
      .NUM_COLS     (NUM_COLS),
      .SCAN_DIV     (SCAN_DIV),
      .BLANK_CYCLES (BLANK_CYCLES),
      .BRIGHT_BITS  (BRIGHT_BITS)
   ) u_timer (
      .clk12MHz   (clk12MHz),
      .rst_n      (rst_n),
      .blank      (blank),
      .col_idx    (col_idx),
      .pwm_cnt    (pwm_cnt),
      .slot_wrap  (slot_wrap),
      .frame_wrap (frame_wrap)
   );

   assign frame_ready = !pending;
   assign accept      = frame_valid && !pending;

   always_comb begin
      col_bits = active[int'(col_idx)*NUM_ROWS +: NUM_ROWS];
      col_oh   = '0;
      col_oh[col_idx] = 1'b1;
      lit = !blank && ((&brightness) || (pwm_cnt < brightness));
   end

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         pend_buf <= '0;
         active   <= '0;
         pending  <= 1'b0;
      end else begin
         // Swap and accept are exclusive: accept needs pending clear
         if (frame_wrap && pending) begin
            active  <= pend_buf;
            pending <= 1'b0;
         end
         if (accept) begin
            pend_buf <= frame_data;
            pending  <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk12MHz or negedge rst_n) begin
      if (!rst_n) begin
         led_n       <= {NUM_ROWS{OFF}};
         lcol_n      <= {NUM_COLS{OFF}};
         frame_start <= 1'b0;
         first_q     <= 1'b1;
      end else begin
         // first_q marks counters sitting at column 0, slot 0
         first_q     <= frame_wrap;
         frame_start <= first_q;
         led_n       <= lit ? ~col_bits : {NUM_ROWS{OFF}};
         lcol_n      <= lit ? ~col_oh : {NUM_COLS{OFF}};
      end
   end

   logic unused_ok;
   assign unused_ok = slot_wrap;

endmodule

// File: doc/led_matrix_scanner.md
Name: led_matrix_scanner

Overview:
Parametrised successor to the fixed 4x8 multiplexed LED display driver. It scans an NUM_COLS x NUM_ROWS LED matrix, one column per time slot. Each slot has a blanking dead-time to prevent ghosting and a global PWM brightness control. A double-buffered frame store with a valid/ready load handshake lets the display swap only at frame boundaries, so there is no tearing. It sits between the design's "video memory" producer logic and the board's active-low row and column pins.

Parameters:
NUM_COLS, 4, number of multiplexed columns (>=1)
NUM_ROWS, 8, LEDs per column (>=1)
SCAN_DIV, 3000, clocks per column slot (must be > BLANK_CYCLES)
BLANK_CYCLES, 24, clocks at the start of each slot with everything off
BRIGHT_BITS, 3, width of the brightness input and the PWM counter

Ports:
clk12MHz  in  1  system clock, 12 MHz
rst_n  in  1  asynchronous reset, active-low
frame_data  in  NUM_COLS*NUM_ROWS  pixel bits; column c occupies [c*NUM_ROWS +: NUM_ROWS], bit r drives row r
frame_valid  in  1  producer offers frame_data
frame_ready  out  1  block can accept a frame (= !pending)
brightness  in  BRIGHT_BITS  global duty; 0 = off, all-ones = 100%
led_n  out  NUM_ROWS  row drivers, active-low
lcol_n  out  NUM_COLS  column enables, active-low
frame_start  out  1  one-cycle pulse marking the first cycle of column 0 of each frame

Behaviour:
Interface: one clock (clk12MHz). Reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.

Reset values (asserted immediately, asynchronously):
- led_n = all 1s, lcol_n = all 1s, frame_start = 0.
- Active and pending buffers cleared to 0; pending flag = 0, so frame_ready = 1.
- slot_cnt = 0, col_idx = 0, pwm_cnt = 0.

Counters:
- slot_cnt counts 0..SCAN_DIV-1 and wraps.
- On wrap, col_idx advances. col_idx wraps from NUM_COLS-1 to 0.

Slot timing:
- Blank phase: slot_cnt < BLANK_CYCLES. lcol_n and led_n are all 1s; pwm_cnt is held at 0.
- Active phase: the remaining slot cycles. pwm_cnt increments every cycle and wraps modulo 2^BRIGHT_BITS.

PWM:
- lit = (brightness == all-ones) OR (pwm_cnt < brightness).
- When lit: lcol_n[col_idx] = 0 and led_n = ~active[col_idx*NUM_ROWS +: NUM_ROWS]. Otherwise all outputs are 1s.

Output timing:
- led_n, lcol_n and frame_start are registered. They lag the internal counter state by exactly one clock.
- No combinational path runs from inputs to these outputs.

Handshake:
- A frame is accepted on a clock edge where frame_valid && frame_ready. frame_data is copied to the pending buffer and pending is set.
- frame_ready drops on the next cycle.
- frame_data may change freely after acceptance.

Frame boundary:
- The boundary is the edge where slot_cnt wraps with col_idx == NUM_COLS-1.
- If pending is set at that edge: pending is copied to active and pending is cleared. Column 0 of the new frame uses the new data.
- frame_start pulses for the first output cycle of column 0.

Simultaneous events:
- If a frame is accepted on the boundary edge itself, the swap uses the old pending state (empty). The new frame is displayed from the following frame onward.
- If pending is already full, frame_ready = 0, so no overwrite is possible.

Rules:
- Brightness is sampled every cycle. A change takes effect within one clock and never corrupts the slot or column sequence.
- Reset mid-frame discards the active frame, the pending frame and the scan position. After release, scanning restarts at column 0, blank phase.

Decomposition:
- Package led_matrix_pkg: default parameter constants (DEF_NUM_COLS, DEF_NUM_ROWS, DEF_SCAN_DIV, DEF_BLANK_CYCLES, DEF_BRIGHT_BITS) and the all-off output constant.
- Sub-module led_slot_timer: owns slot_cnt, col_idx and pwm_cnt. It exports blank, col_idx, pwm_cnt, slot_wrap and frame_wrap.
- The top level holds the buffers, the handshake and the output registers.

Test Plan:
Bench parameters: NUM_COLS=4, NUM_ROWS=8, SCAN_DIV=16, BLANK_CYCLES=2, BRIGHT_BITS=3.
1. Reset: hold rst_n=0 -> led_n=8'hFF, lcol_n=4'hF, frame_ready=1, frame_start=0. Release -> the first two output cycles of column 0 are all-off.
2. Load frame_data=32'hA53C0F81 with brightness=7 -> after the next frame_start, the column-0 active phase gives lcol_n=4'hE, led_n=8'h7E. Column 1 gives 4'hD, 8'hF0. Column 2 gives 4'hB, 8'hC3. Column 3 gives 4'h7, 8'h5A.
3. brightness=2 -> exactly 4 lit cycles per 14-cycle active window (pwm_cnt 0,1 in each 8-count). brightness=0 -> lcol_n stays 4'hF for a whole frame.
4. Accept frame A, then hold frame_valid with frame B -> frame_ready=0 until the boundary. A is displayed for a full frame without change mid-frame, and B is accepted right after the swap.
5. Accept a frame on the same edge as the frame boundary -> the frame then starting still shows the old data. The new data appears at the next frame_start.
6. Assert rst_n=0 during the column-2 active phase -> outputs go all-off without waiting for a clock edge. After release, the display is blank (buffer cleared) and scanning restarts at column 0.
